rgb_hsv_stream: RTL and testbench

RGB_HSV_STREAM -- requirements
Module: rgb_hsv_stream

---
 rtl/hsv_pkg.sv | 32 +++
 rtl/rgb_hsv_stream_if.sv | 35 +++
 rtl/hsv_div_stage.sv | 31 +++
 rtl/rgb_hsv_stream.sv | 219 +++++++++++++++++++++
 tb/tb_rgb_hsv_stream.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/hsv_pkg.sv
// Shared types and helpers for the RGB->HSV streaming pipeline.
// Sector select, per-stage metadata and latency formula live here.
package hsv_pkg;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int lat_of(input int ch_w);
        return ch_w + 3;
    endfunction

    typedef enum logic [1:0] {
        SEC_R,
        SEC_G,
        SEC_B
    } sec_e;

    typedef struct packed {
        sec_e sec;
        logic neg;
    } meta_t;

endpackage

// File: rtl/rgb_hsv_stream_if.sv
// Pixel-in / HSV-out stream bundle with valid/ready handshakes.
// master drives pixels and out_ready; slave is the converter.
interface rgb_hsv_stream_if #(
    parameter int CH_W   = 8,
    parameter int H_MAX  = 360,
    parameter int USER_W = 2
);
    import hsv_pkg::*;

    localparam int HUE_W = clog2(H_MAX);

    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_r;
    logic [CH_W-1:0]   in_g;
    logic [CH_W-1:0]   in_b;
    logic [USER_W-1:0] in_user;
    logic              out_valid;
    logic              out_ready;
    logic [HUE_W-1:0]  out_h;
    logic [CH_W-1:0]   out_s;
    logic [CH_W-1:0]   out_v;
    logic [USER_W-1:0] out_user;

    modport master (
        output in_valid, in_r, in_g, in_b, in_user, out_ready,
        input  in_ready, out_valid, out_h, out_s, out_v, out_user
    );

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_user, out_ready,
        output in_ready, out_valid, out_h, out_s, out_v, out_user
    );

endinterface

// File: rtl/hsv_div_stage.sv
// One registered restoring-division step: shifts one dividend bit
// into the remainder and one quotient bit into quo.
module hsv_div_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] dsr,
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] t;
    logic       ge;

    always_comb begin
        t  = {rem_i, quo_i[W-1]};
        ge = t >= {1'b0, dsr};
    end

    // remainder stays below dsr, so t - dsr always fits in W bits
    always_ff @(posedge clk) begin
        if (en) begin
            rem_o <= ge ? W'(t - {1'b0, dsr}) : t[W-1:0];
            quo_o <= {quo_i[W-2:0], ge};
        end
    end

endmodule

// File: rtl/rgb_hsv_stream.sv
// RGB->HSV converter, CH_W+3 stage stall-able pipeline.
// Define HSV_ROUND_EN for round-to-nearest quotients (default truncates).
module rgb_hsv_stream
    import hsv_pkg::*;
#(
    parameter int CH_W   = 8,
    parameter int H_MAX  = 360,
    parameter int USER_W = 2
) (
    input logic clk,
    input logic rst,
    rgb_hsv_stream_if.slave bus
);

    localparam int HUE_W = clog2(H_MAX);
    localparam int LAT   = lat_of(CH_W);
    localparam int W2    = 2 * CH_W;
    localparam int AW    = ((HUE_W > CH_W) ? HUE_W : CH_W) + 2;

    localparam logic [CH_W-1:0] H6   = CH_W'(H_MAX / 6);
    localparam logic [CH_W-1:0] FULL = '1;
    localparam logic [AW-1:0]   HM   = AW'(H_MAX);
    localparam logic [AW-1:0]   HB_G = AW'(H_MAX / 3);
    localparam logic [AW-1:0]   HB_B = AW'(2 * H_MAX / 3);

    logic           en;
    logic [LAT-1:0] vld;

    assign en            = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[LAT-2:0], bus.in_valid};
        end
    end

    logic              rmax;
    logic              gmax;
    logic [CH_W-1:0]   mx1;
    logic [CH_W-1:0]   mn1;
    logic [CH_W-1:0]   x1;
    logic [CH_W-1:0]   y1;
    meta_t             m1;

    always_comb begin
        rmax   = (bus.in_r >= bus.in_g) && (bus.in_r >= bus.in_b);
        gmax   = !rmax && (bus.in_g >= bus.in_b);
        mx1    = bus.in_b;
        x1     = bus.in_r;
        y1     = bus.in_g;
        m1.sec = SEC_B;
        unique case (1'b1)
            rmax: begin
                mx1    = bus.in_r;
                x1     = bus.in_g;
                y1     = bus.in_b;
                m1.sec = SEC_R;
            end
            gmax: begin
                mx1    = bus.in_g;
                x1     = bus.in_b;
                y1     = bus.in_r;
                m1.sec = SEC_G;
            end
            default: ;
        endcase
        m1.neg = x1 < y1;
        mn1    = bus.in_r;
        if (bus.in_g < mn1) mn1 = bus.in_g;
        if (bus.in_b < mn1) mn1 = bus.in_b;
    end

    logic [CH_W-1:0]   s1_mx;
    logic [CH_W-1:0]   s1_df;
    logic [CH_W-1:0]   s1_n;
    meta_t             s1_meta;
    logic [USER_W-1:0] s1_user;

    logic [W2-1:0]     s2_hd;
    logic [W2-1:0]     s2_sd;
    logic [CH_W-1:0]   s2_mx;
    logic [CH_W-1:0]   s2_df;
    meta_t             s2_meta;
    logic [USER_W-1:0] s2_user;

    logic [W2-1:0]     hd_nx;
    logic [W2-1:0]     sd_nx;

    always_comb begin
        hd_nx = W2'(s1_n) * W2'(H6);
        sd_nx = W2'(s1_df) * W2'(FULL);
`ifdef HSV_ROUND_EN
        hd_nx = hd_nx + W2'(s1_df >> 1);
        sd_nx = sd_nx + W2'(s1_mx >> 1);
`endif
    end

    logic [CH_W-1:0]   cm_mx   [1:CH_W];
    logic [CH_W-1:0]   cm_df   [1:CH_W];
    meta_t             cm_meta [1:CH_W];
    logic [USER_W-1:0] cm_user [1:CH_W];

    always_ff @(posedge clk) begin
        if (en) begin
            s1_mx   <= mx1;
            s1_df   <= mx1 - mn1;
            s1_n    <= m1.neg ? y1 - x1 : x1 - y1;
            s1_meta <= m1;
            s1_user <= bus.in_user;
            s2_hd   <= hd_nx;
            s2_sd   <= sd_nx;
            s2_mx   <= s1_mx;
            s2_df   <= s1_df;
            s2_meta <= s1_meta;
            s2_user <= s1_user;
            cm_mx[1]   <= s2_mx;
            cm_df[1]   <= s2_df;
            cm_meta[1] <= s2_meta;
            cm_user[1] <= s2_user;
            for (int j = 2; j <= CH_W; j++) begin
                cm_mx[j]   <= cm_mx[j-1];
                cm_df[j]   <= cm_df[j-1];
                cm_meta[j] <= cm_meta[j-1];
                cm_user[j] <= cm_user[j-1];
            end
        end
    end

    logic [CH_W-1:0] hr [1:CH_W];
    logic [CH_W-1:0] hq [1:CH_W];
    logic [CH_W-1:0] sr [1:CH_W];
    logic [CH_W-1:0] sq [1:CH_W];

    for (genvar j = 0; j < CH_W; j++) begin : g_div
        logic [CH_W-1:0] h_dsr, h_rem, h_quo;
        logic [CH_W-1:0] s_dsr, s_rem, s_quo;

        if (j == 0) begin : g_first
            assign h_dsr = s2_df;
            assign h_rem = s2_hd[W2-1:CH_W];
            assign h_quo = s2_hd[CH_W-1:0];
            assign s_dsr = s2_mx;
            assign s_rem = s2_sd[W2-1:CH_W];
            assign s_quo = s2_sd[CH_W-1:0];
        end else begin : g_next
            assign h_dsr = cm_df[j];
            assign h_rem = hr[j];
            assign h_quo = hq[j];
            assign s_dsr = cm_mx[j];
            assign s_rem = sr[j];
            assign s_quo = sq[j];
        end

        hsv_div_stage #(.W(CH_W)) u_hue (
            .clk   (clk),
            .en    (en),
            .dsr   (h_dsr),
            .rem_i (h_rem),
            .quo_i (h_quo),
            .rem_o (hr[j+1]),
            .quo_o (hq[j+1])
        );

        hsv_div_stage #(.W(CH_W)) u_sat (
            .clk   (clk),
            .en    (en),
            .dsr   (s_dsr),
            .rem_i (s_rem),
            .quo_i (s_quo),
            .rem_o (sr[j+1]),
            .quo_o (sq[j+1])
        );
    end

    logic unused_rem;
    assign unused_rem = ^{hr[CH_W], sr[CH_W]};

    meta_t            fm;
    logic             flat;
    logic [AW-1:0]    base;
    logic [AW-1:0]    t;
    logic [HUE_W-1:0] h_nx;
    logic [CH_W-1:0]  s_nx;

    // negative offsets are folded by adding H_MAX before the single wrap
    always_comb begin
        fm   = cm_meta[CH_W];
        flat = cm_df[CH_W] == '0;
        unique case (fm.sec)
            SEC_G:   base = HB_G;
            SEC_B:   base = HB_B;
            default: base = '0;
        endcase
        if (fm.neg) t = base + HM - AW'(hq[CH_W]);
        else        t = base + AW'(hq[CH_W]);
        if (t >= HM) t = t - HM;
        h_nx = flat ? '0 : t[HUE_W-1:0];
        s_nx = flat ? '0 : sq[CH_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_h    <= '0;
            bus.out_s    <= '0;
            bus.out_v    <= '0;
            bus.out_user <= '0;
        end else if (en) begin
            bus.out_h    <= h_nx;
            bus.out_s    <= s_nx;
            bus.out_v    <= cm_mx[CH_W];
            bus.out_user <= cm_user[CH_W];
        end
    end

endmodule

// File: tb/tb_rgb_hsv_stream.sv
// Directed self-checking bench for rgb_hsv_stream (CH_W=8, H_MAX=360).
// Honours HSV_ROUND_EN for the rounding-dependent expectations.
module tb_rgb_hsv_stream;

    localparam int CH_W   = 8;
    localparam int H_MAX  = 360;
    localparam int USER_W = 2;
    localparam int LAT    = 11;

`ifdef HSV_ROUND_EN
    localparam int S_200 = 128;
`else
    localparam int S_200 = 127;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rgb_hsv_stream_if #(
        .CH_W(CH_W), .H_MAX(H_MAX), .USER_W(USER_W)
    ) bus ();

    rgb_hsv_stream #(
        .CH_W(CH_W), .H_MAX(H_MAX), .USER_W(USER_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_h(input int i);
`ifdef HSV_ROUND_EN
        return (i * 480 + 127) / 255;
`else
        return (i * 480) / 255;
`endif
    endfunction

    task automatic drive(input int r, input int g, input int b,
                         input int u);
        bus.in_valid = 1'b1;
        bus.in_r     = 8'(r);
        bus.in_g     = 8'(g);
        bus.in_b     = 8'(b);
        bus.in_user  = 2'(u);
    endtask

    task automatic pix(input string tag, input int r, input int g,
                       input int b, input int u, input int eh,
                       input int es, input int ev);
        @(posedge clk);
        #1 drive(r, g, b, u);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (LAT - 2) @(posedge clk);
        #1 chk({tag, "_early"}, 32'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_h"}, 32'(bus.out_h), eh);
        chk({tag, "_s"}, 32'(bus.out_s), es);
        chk({tag, "_v"}, 32'(bus.out_v), ev);
        chk({tag, "_user"}, 32'(bus.out_user), u);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int rcv;
        int cyc;
        int seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_g      = '0;
        bus.in_b      = '0;
        bus.in_user   = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_h", 32'(bus.out_h), 0);
        chk("rst_s", 32'(bus.out_s), 0);
        chk("rst_v", 32'(bus.out_v), 0);
        chk("rst_user", 32'(bus.out_user), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rel_ready", 32'(bus.in_ready), 1);

        pix("red",   255,   0,   0, 1,   0, 255, 255);
        pix("green",   0, 255,   0, 2, 120, 255, 255);
        pix("blue",    0,   0, 255, 3, 240, 255, 255);
        pix("orange", 255, 128,  0, 0,  30, 255, 255);
        pix("rose",  255,   0, 128, 1, 330, 255, 255);
        pix("grey",  128, 128, 128, 2,   0,   0, 128);
        pix("black",   0,   0,   0, 3,   0,   0,   0);
        pix("pink",  200, 100, 100, 0,   0, S_200, 200);
        pix("navy",   10,  20,  30, 1, 210, 170,  30);
        pix("leaf",  100, 200,  50, 2, 100, 191, 200);
        pix("tie_rg", 255, 255,  0, 3,  60, 255, 255);
        pix("magenta", 255, 0, 255, 0, 300, 255, 255);

        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while (rcv < 32 && cyc < 300) begin
            @(posedge clk);
            #1;
            bus.out_ready = !(cyc >= 15 && cyc < 20);
            if (sent < 32) drive(255, 8 * sent, 0, sent % 4);
            else bus.in_valid = 1'b0;
            #1;
            if (!bus.out_ready) begin
                chk("stall_ready", 32'(bus.in_ready), 0);
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_h", 32'(bus.out_h), exp_h(rcv));
                chk("stall_user", 32'(bus.out_user), rcv % 4);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("strm_h", 32'(bus.out_h), exp_h(rcv));
                chk("strm_s", 32'(bus.out_s), 255);
                chk("strm_user", 32'(bus.out_user), rcv % 4);
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        chk("strm_count", rcv, 32);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen++;
        end
        chk("strm_nodup", seen, 0);

        for (int k = 0; k < 6; k++) begin
            drive(255, 128, 0, 3);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        chk("pre_rst_h", 32'(bus.out_h), 30);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_h", 32'(bus.out_h), 0);
        chk("arst_s", 32'(bus.out_s), 0);
        chk("arst_v", 32'(bus.out_v), 0);
        chk("arst_user", 32'(bus.out_user), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("post_rst_ready", 32'(bus.in_ready), 1);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen++;
        end
        chk("flushed", seen, 0);
        pix("after_rst", 0, 255, 0, 1, 120, 255, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
